// File: rtl/pwl_line_sequencer_if.sv
// Line-table bundle shared by the register group (writer) and the PWL generator (reader).
interface IRegs #(
  parameter int PARAM_SIZE = 32,
  parameter int POINTS     = 9
);
  logic [PARAM_SIZE-1:0] linea     [POINTS];
  logic [PARAM_SIZE-1:0] linet     [POINTS];
  logic [PARAM_SIZE-1:0] linet_int [POINTS];
  logic [PARAM_SIZE-1:0] offset    [POINTS];
  logic [PARAM_SIZE-1:0] linenmb;
  logic [PARAM_SIZE-1:0] repeatcycle;

  modport in (input linea, linet, linet_int, offset, linenmb, repeatcycle);
endinterface

// File: rtl/pwl_line_sequencer.sv
// Plays a snapshot of the line table as a piecewise-linear signed sample stream,
// one accumulated sample per step with interval spacing, line skipping and pass repeats.
module pwl_line_sequencer #(
  parameter int PARAM_SIZE = 32,
  parameter int POINTS     = 9
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  IRegs.in                              regs,
  input  logic                          start,
  input  logic                          stop,
  output logic                          busy,
  output logic                          done,
  output logic                          sample_valid,
  output logic signed [PARAM_SIZE-1:0]  sample,
  output logic [$clog2(POINTS)-1:0]     line_idx
);
  localparam int IW = $clog2(POINTS);
  localparam int CW = IW + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_NEXT = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic signed [PARAM_SIZE-1:0] sh_a   [POINTS];
  logic signed [PARAM_SIZE-1:0] sh_off [POINTS];
  logic        [PARAM_SIZE-1:0] sh_t   [POINTS];
  logic        [PARAM_SIZE-1:0] sh_int [POINTS];
  logic        [CW-1:0]         lines;

  logic [2:0]                   state, state_d;
  logic [CW-1:0]                pos, pos_d;
  logic [PARAM_SIZE-1:0]        cnt, cnt_d;
  logic [PARAM_SIZE-1:0]        gap, gap_d;
  logic [PARAM_SIZE-1:0]        passes, passes_d;
  logic signed [PARAM_SIZE-1:0] acc_p0, acc_d;
  logic signed [PARAM_SIZE-1:0] sample_d;
  logic [IW-1:0]                idx_d;
  logic                         vld_d;

  logic                         accept, adv, enter;
  logic [CW-1:0]                tgt, nxt;
  logic [IW-1:0]                ti, cur;

  function automatic logic signed [PARAM_SIZE-1:0] wrap_add(
    input logic signed [PARAM_SIZE-1:0] x,
    input logic signed [PARAM_SIZE-1:0] y
  );
    return x + y;
  endfunction

  assign accept = (state == S_IDLE) && start && !stop;
  assign cur    = pos[IW-1:0];
  assign busy   = (state == S_LOAD) || (state == S_RUN) || (state == S_NEXT);
  assign done   = (state == S_FIN);

  // Snapshot taken on the accepting edge, so the table is stable from LOAD onward
  always_ff @(posedge aclk) begin
    if (accept) begin
      for (int i = 0; i < POINTS; i++) begin
        sh_a[i]   <= $signed(regs.linea[i]);
        sh_off[i] <= $signed(regs.offset[i]);
        sh_t[i]   <= regs.linet[i];
        sh_int[i] <= regs.linet_int[i];
      end
      lines <= (regs.linenmb > PARAM_SIZE'(POINTS)) ? CW'(POINTS) : regs.linenmb[CW-1:0];
    end
  end

  always_comb begin
    state_d  = state;
    pos_d    = pos;
    cnt_d    = cnt;
    gap_d    = gap;
    passes_d = passes;
    acc_d    = acc_p0;
    sample_d = sample;
    idx_d    = line_idx;
    vld_d    = 1'b0;
    adv      = 1'b0;
    enter    = 1'b0;
    tgt      = '0;
    nxt      = pos + 1'b1;
    ti       = '0;

    case (state)
      S_IDLE: if (accept) begin
        state_d  = S_LOAD;
        passes_d = regs.repeatcycle;
      end
      S_LOAD: begin
        if (stop)               state_d = S_IDLE;
        else if (lines == '0)   state_d = S_FIN;
        else                    enter   = 1'b1;
      end
      S_RUN: begin
        if (stop)               state_d = S_IDLE;
        else if (gap != '0)     gap_d   = gap - 1'b1;
        else if (cnt != '0) begin
          vld_d    = 1'b1;
          sample_d = acc_p0;
          idx_d    = cur;
          acc_d    = wrap_add(acc_p0, sh_a[cur]);
          cnt_d    = cnt - 1'b1;
          gap_d    = sh_int[cur];
        end else                adv     = 1'b1;
      end
      S_NEXT: begin
        if (stop)               state_d = S_IDLE;
        else if (pos >= lines)  state_d = S_FIN;
        else                    adv     = 1'b1;
      end
      S_FIN:                    state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase

    // passes==0 means repeat forever; otherwise it counts down to the final pass
    if (adv) begin
      if (nxt < lines) begin
        enter = 1'b1;
        tgt   = nxt;
      end else if (passes == '0 || passes != PARAM_SIZE'(1)) begin
        enter = 1'b1;
        if (passes != '0) passes_d = passes - 1'b1;
      end else begin
        state_d = S_NEXT;
        pos_d   = lines;
      end
    end

    // Entering a line emits its first sample on the same edge, or spends a NEXT cycle if empty
    if (enter) begin
      ti    = tgt[IW-1:0];
      pos_d = tgt;
      if (sh_t[ti] == '0) begin
        state_d = S_NEXT;
      end else begin
        state_d  = S_RUN;
        vld_d    = 1'b1;
        sample_d = sh_off[ti];
        idx_d    = ti;
        acc_d    = wrap_add(sh_off[ti], sh_a[ti]);
        cnt_d    = sh_t[ti] - 1'b1;
        gap_d    = sh_int[ti];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state        <= S_IDLE;
      pos          <= '0;
      cnt          <= '0;
      gap          <= '0;
      passes       <= '0;
      sample_valid <= 1'b0;
      sample       <= '0;
      line_idx     <= '0;
    end else begin
      state        <= state_d;
      pos          <= pos_d;
      cnt          <= cnt_d;
      gap          <= gap_d;
      passes       <= passes_d;
      sample_valid <= vld_d;
      sample       <= sample_d;
      line_idx     <= idx_d;
    end
  end

  always_ff @(posedge aclk) begin
    acc_p0 <= acc_d;
  end
endmodule

// File: tb/tb_pwl_line_sequencer.sv
// Directed bench for pwl_line_sequencer: each scenario task drives a run and checks the stream.
module tb_pwl_line_sequencer;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy, done, sample_valid;
  logic [31:0] sample;
  logic [3:0]  line_idx;

  int tests = 0;
  int fails = 0;

  logic        rb [0:1100];
  logic        rd [0:1100];
  logic        rv [0:1100];
  logic [31:0] rs [0:1100];
  logic [3:0]  ri [0:1100];
  int          vc[$];
  logic [31:0] vs[$];
  logic [3:0]  vi[$];
  int          dc[$];

  IRegs #(.PARAM_SIZE(32), .POINTS(9)) regs_if ();

  pwl_line_sequencer #(.PARAM_SIZE(32), .POINTS(9)) dut (
    .aclk(aclk), .aresetn(aresetn), .regs(regs_if), .start(start), .stop(stop),
    .busy(busy), .done(done), .sample_valid(sample_valid), .sample(sample), .line_idx(line_idx)
  );

  always #5 aclk = ~aclk;

  task automatic clear_table(input int nmb, input int rep);
    for (int i = 0; i < 9; i++) begin
      regs_if.linea[i] = '0; regs_if.linet[i] = '0;
      regs_if.linet_int[i] = '0; regs_if.offset[i] = '0;
    end
    regs_if.linenmb = nmb;
    regs_if.repeatcycle = rep;
  endtask

  task automatic set_line(input int i, input int off, input int a, input int t, input int it);
    regs_if.offset[i] = off; regs_if.linea[i] = a;
    regs_if.linet[i] = t; regs_if.linet_int[i] = it;
  endtask

  // Start pulse sampled at edge 0; cycle c is observed on the negedge after edge c-1
  task automatic go(input int ncyc, input int start_a, input int start_b,
                    input int stop_at, input int mod_at, input int rst_at);
    vc.delete(); vs.delete(); vi.delete(); dc.delete();
    start = 1'b1;
    stop  = (stop_at == 0);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge aclk);
      start = 1'b0; stop = 1'b0; aresetn = 1'b1;
      rb[c] = busy; rd[c] = done; rv[c] = sample_valid; rs[c] = sample; ri[c] = line_idx;
      if (sample_valid) begin vc.push_back(c); vs.push_back(sample); vi.push_back(line_idx); end
      if (done) dc.push_back(c);
      if (c == start_a || c == start_b) start = 1'b1;
      if (c == stop_at) stop = 1'b1;
      if (c == rst_at) aresetn = 1'b0;
      if (c == mod_at) begin
        regs_if.linea[0] = 99; regs_if.offset[0] = 0; regs_if.linenmb = 0;
      end
    end
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    @(negedge aclk); @(negedge aclk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", sample_valid); end
    tests++; if (sample !== 32'd0) begin fails++; $display("FAIL reset_sample got %h want 0", sample); end
    tests++; if (line_idx !== 4'd0) begin fails++; $display("FAIL reset_idx got %0d want 0", line_idx); end
    aresetn = 1'b1;
    @(negedge aclk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_basic_ramp;
    clear_table(1, 1); set_line(0, 100, 5, 4, 0);
    go(10, -1, -1, -1, -1, -1);
    tests++; if (vc.size() != 4) begin fails++; $display("FAIL ramp_count got %0d want 4", vc.size()); end
    for (int k = 0; k < 4 && k < vc.size(); k++) begin
      tests++;
      if (vc[k] != 2 + k || vs[k] !== 32'(100 + 5 * k) || vi[k] !== 4'd0) begin
        fails++; $display("FAIL ramp_s%0d got c=%0d v=%0d i=%0d want c=%0d v=%0d i=0",
                          k, vc[k], $signed(vs[k]), vi[k], 2 + k, 100 + 5 * k);
      end
    end
    tests++; if (dc.size() != 1 || dc[0] != 7) begin fails++; $display("FAIL ramp_done got n=%0d c=%0d want n=1 c=7", dc.size(), dc.size() ? dc[0] : -1); end
    for (int c = 1; c <= 9; c++) begin
      tests++; if (rb[c] !== (c <= 6)) begin fails++; $display("FAIL ramp_busy@%0d got %b want %b", c, rb[c], (c <= 6)); end
    end
  endtask

  task automatic test_interval_multi;
    int ec[4] = '{2, 5, 8, 9};
    int ev[4] = '{0, 1, -10, -13};
    int ei[4] = '{0, 0, 1, 1};
    clear_table(2, 1); set_line(0, 0, 1, 2, 2); set_line(1, -10, -3, 2, 0);
    go(14, -1, -1, -1, -1, -1);
    tests++; if (vc.size() != 4) begin fails++; $display("FAIL multi_count got %0d want 4", vc.size()); end
    for (int k = 0; k < 4 && k < vc.size(); k++) begin
      tests++;
      if (vc[k] != ec[k] || vs[k] !== 32'(ev[k]) || vi[k] !== 4'(ei[k])) begin
        fails++; $display("FAIL multi_s%0d got c=%0d v=%0d i=%0d want c=%0d v=%0d i=%0d",
                          k, vc[k], $signed(vs[k]), vi[k], ec[k], ev[k], ei[k]);
      end
    end
    tests++; if (dc.size() != 1 || dc[0] != 11) begin fails++; $display("FAIL multi_done got n=%0d c=%0d want n=1 c=11", dc.size(), dc.size() ? dc[0] : -1); end
  endtask

  task automatic test_clamp;
    clear_table(12, 1);
    for (int i = 0; i < 9; i++) set_line(i, 10 * i, 0, 1, 0);
    go(16, -1, -1, -1, -1, -1);
    tests++; if (vc.size() != 9) begin fails++; $display("FAIL clamp_count got %0d want 9", vc.size()); end
    for (int k = 0; k < 9 && k < vc.size(); k++) begin
      tests++;
      if (vc[k] != 2 + k || vs[k] !== 32'(10 * k) || vi[k] !== 4'(k)) begin
        fails++; $display("FAIL clamp_s%0d got c=%0d v=%0d i=%0d want c=%0d v=%0d i=%0d",
                          k, vc[k], $signed(vs[k]), vi[k], 2 + k, 10 * k, k);
      end
    end
    tests++; if (dc.size() != 1 || dc[0] != 12) begin fails++; $display("FAIL clamp_done got n=%0d c=%0d want n=1 c=12", dc.size(), dc.size() ? dc[0] : -1); end
  endtask

  task automatic test_zero_line;
    clear_table(3, 1); set_line(0, 7, 1, 1, 0); set_line(1, 55, 1, 0, 0); set_line(2, 9, 1, 1, 0);
    go(9, -1, -1, -1, -1, -1);
    tests++;
    if (vc.size() != 2 || vc[0] != 2 || vs[0] !== 32'd7 || vi[0] !== 4'd0 ||
        vc[1] != 4 || vs[1] !== 32'd9 || vi[1] !== 4'd2) begin
      fails++; $display("FAIL zero_mid got n=%0d c1=%0d v1=%0d want n=2 c0=2 v0=7 c1=4 v1=9 i1=2",
                        vc.size(), vc.size() > 1 ? vc[1] : -1, vs.size() > 1 ? $signed(vs[1]) : -1);
    end
    tests++; if (dc.size() != 1 || dc[0] != 6) begin fails++; $display("FAIL zero_mid_done got n=%0d want c=6", dc.size()); end
    clear_table(2, 1); set_line(0, 44, 1, 0, 0); set_line(1, 3, 1, 1, 0);
    go(8, -1, -1, -1, -1, -1);
    tests++;
    if (vc.size() != 1 || vc[0] != 3 || vs[0] !== 32'd3 || vi[0] !== 4'd1) begin
      fails++; $display("FAIL zero_first got n=%0d c=%0d want n=1 c=3 v=3 i=1", vc.size(), vc.size() ? vc[0] : -1);
    end
    tests++; if (dc.size() != 1 || dc[0] != 5) begin fails++; $display("FAIL zero_first_done got n=%0d want c=5", dc.size()); end
  endtask

  task automatic test_wrap_and_empty;
    clear_table(1, 1); set_line(0, 32'h7FFFFFFF, 1, 2, 0);
    go(7, -1, -1, -1, -1, -1);
    tests++;
    if (vc.size() != 2 || vs[0] !== 32'h7FFFFFFF || vs[1] !== 32'h80000000) begin
      fails++; $display("FAIL wrap got n=%0d v0=%h v1=%h want 7fffffff 80000000",
                        vc.size(), vs.size() ? vs[0] : 32'd0, vs.size() > 1 ? vs[1] : 32'd0);
    end
    clear_table(0, 1); set_line(0, 5, 1, 3, 0);
    go(6, -1, -1, -1, -1, -1);
    tests++; if (vc.size() != 0) begin fails++; $display("FAIL empty_valid got %0d want 0", vc.size()); end
    tests++; if (dc.size() != 1 || dc[0] != 2) begin fails++; $display("FAIL empty_done got n=%0d want c=2", dc.size()); end
    tests++; if (rb[1] !== 1'b1 || rb[2] !== 1'b0) begin fails++; $display("FAIL empty_busy got %b%b want 10", rb[1], rb[2]); end
  endtask

  task automatic test_repeat;
    clear_table(1, 3); set_line(0, 50, 2, 2, 0);
    go(12, -1, -1, -1, -1, -1);
    tests++; if (vc.size() != 6) begin fails++; $display("FAIL rep_count got %0d want 6", vc.size()); end
    for (int k = 0; k < 6 && k < vc.size(); k++) begin
      tests++;
      if (vc[k] != 2 + k || vs[k] !== ((k % 2) ? 32'd52 : 32'd50)) begin
        fails++; $display("FAIL rep_s%0d got c=%0d v=%0d want c=%0d v=%0d", k, vc[k], $signed(vs[k]), 2 + k, (k % 2) ? 52 : 50);
      end
    end
    tests++; if (dc.size() != 1 || dc[0] != 9) begin fails++; $display("FAIL rep_done got n=%0d want n=1 c=9", dc.size()); end
  endtask

  task automatic test_forever_stop;
    clear_table(1, 0); set_line(0, 50, 2, 2, 0);
    go(1010, -1, -1, 1000, -1, -1);
    tests++; if (vc.size() != 999) begin fails++; $display("FAIL forever_count got %0d want 999", vc.size()); end
    tests++; if (dc.size() != 0) begin fails++; $display("FAIL forever_done got %0d want 0", dc.size()); end
    tests++; if (rv[1000] !== 1'b1) begin fails++; $display("FAIL forever_last_valid got %b want 1", rv[1000]); end
    tests++;
    if (rb[1001] !== 1'b0 || rv[1001] !== 1'b0 || rs[1001] !== 32'd50) begin
      fails++; $display("FAIL forever_stop got busy=%b vld=%b s=%0d want 0 0 50", rb[1001], rv[1001], rs[1001]);
    end
  endtask

  task automatic test_stop_mid_line;
    clear_table(1, 1); set_line(0, 100, 5, 4, 2);
    go(16, -1, -1, 6, -1, -1);
    tests++; if (vc.size() != 2) begin fails++; $display("FAIL stop_count got %0d want 2", vc.size()); end
    tests++;
    if (rb[7] !== 1'b0 || rv[7] !== 1'b0 || rs[7] !== 32'd105 || ri[7] !== 4'd0) begin
      fails++; $display("FAIL stop_state got busy=%b vld=%b s=%0d want 0 0 105", rb[7], rv[7], rs[7]);
    end
    tests++; if (dc.size() != 0) begin fails++; $display("FAIL stop_done got %0d want 0", dc.size()); end
    tests++; if (rs[16] !== 32'd105) begin fails++; $display("FAIL stop_hold got %0d want 105", rs[16]); end
  endtask

  task automatic test_ignored_inputs;
    clear_table(1, 1); set_line(0, 100, 5, 4, 0);
    go(12, 3, 7, -1, 2, -1);
    tests++; if (vc.size() != 4) begin fails++; $display("FAIL ign_count got %0d want 4", vc.size()); end
    for (int k = 0; k < 4 && k < vc.size(); k++) begin
      tests++;
      if (vc[k] != 2 + k || vs[k] !== 32'(100 + 5 * k)) begin
        fails++; $display("FAIL ign_s%0d got c=%0d v=%0d want c=%0d v=%0d", k, vc[k], $signed(vs[k]), 2 + k, 100 + 5 * k);
      end
    end
    tests++; if (dc.size() != 1 || dc[0] != 7) begin fails++; $display("FAIL ign_done got n=%0d want n=1 c=7", dc.size()); end
    tests++; if (rb[8] !== 1'b0 || rb[9] !== 1'b0) begin fails++; $display("FAIL ign_fin_start got %b%b want 00", rb[8], rb[9]); end
    clear_table(1, 1); set_line(0, 100, 5, 4, 0);
    go(8, -1, -1, 0, -1, -1);
    tests++;
    if (vc.size() != 0 || rb[1] !== 1'b0 || dc.size() != 0) begin
      fails++; $display("FAIL startstop_idle got n=%0d busy=%b done=%0d want 0 0 0", vc.size(), rb[1], dc.size());
    end
  endtask

  task automatic test_reset_mid_run;
    clear_table(1, 1); set_line(0, 100, 5, 4, 0);
    go(8, -1, -1, -1, -1, 3);
    tests++;
    if (rb[4] !== 1'b0 || rd[4] !== 1'b0 || rv[4] !== 1'b0 || rs[4] !== 32'd0 || ri[4] !== 4'd0) begin
      fails++; $display("FAIL rstrun_outputs got b=%b d=%b v=%b s=%0d i=%0d want all 0", rb[4], rd[4], rv[4], rs[4], ri[4]);
    end
    tests++; if (vc.size() != 2 || dc.size() != 0 || rb[6] !== 1'b0) begin fails++; $display("FAIL rstrun_abort got n=%0d d=%0d want 2 0", vc.size(), dc.size()); end
    go(10, -1, -1, -1, -1, -1);
    tests++; if (vc.size() != 4) begin fails++; $display("FAIL rstrun_again_count got %0d want 4", vc.size()); end
    for (int k = 0; k < 4 && k < vc.size(); k++) begin
      tests++;
      if (vc[k] != 2 + k || vs[k] !== 32'(100 + 5 * k)) begin
        fails++; $display("FAIL rstrun_again_s%0d got c=%0d v=%0d want c=%0d v=%0d", k, vc[k], $signed(vs[k]), 2 + k, 100 + 5 * k);
      end
    end
    tests++; if (dc.size() != 1 || dc[0] != 7) begin fails++; $display("FAIL rstrun_again_done got n=%0d want c=7", dc.size()); end
  endtask

  initial begin
    clear_table(0, 0);
    test_reset;
    test_basic_ramp;
    test_interval_multi;
    test_clamp;
    test_zero_line;
    test_wrap_and_empty;
    test_repeat;
    test_forever_stop;
    test_stop_mid_line;
    test_ignored_inputs;
    test_reset_mid_run;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
